// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline types: control-bundle bit map and bubble value.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int CTRL_W        = 8;

    // Control bundle layout: {aluop[1:0], alusrc, branch, memtoreg, memwrite, memread, regwrite}
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP    = 6;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Brief    : ID-side inputs and EX-side registered outputs of the ID/EX stage.
// Revision : 1.0
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
);
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [4:0]        id_rs1_i;
    logic [4:0]        id_rs2_i;
    logic [4:0]        id_rd_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [2:0]        id_funct3_i;
    logic              id_funct7b5_i;
    logic [CTRL_W-1:0] id_ctrl_i;

    logic              ex_valid_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic [4:0]        ex_rs1_o;
    logic [4:0]        ex_rs2_o;
    logic [4:0]        ex_rd_o;
    logic [2:0]        ex_funct3_o;
    logic              ex_funct7b5_o;
    logic [CTRL_W-1:0] ex_ctrl_o;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_rs1_used_i, id_rs2_used_i,
               id_funct3_i, id_funct7b5_i, id_ctrl_i,
        input  ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o, ex_ctrl_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_rs1_used_i, id_rs2_used_i,
               id_funct3_i, id_funct7b5_i, id_ctrl_i,
        output ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o, ex_ctrl_o
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use compare between the EX load and ID reader.
// Revision : 1.0
// ============================================================================
module hazard_detect (
    input  wire       i_ex_valid,
    input  wire       i_ex_memread,
    input  wire [4:0] i_ex_rd,
    input  wire       i_id_valid,
    input  wire [4:0] i_id_rs1,
    input  wire [4:0] i_id_rs2,
    input  wire       i_id_rs1_used,
    input  wire       i_id_rs2_used,
    output logic      o_load_use
);

    logic w_ex_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 as load destination never produces a hazard
    assign w_ex_load  = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0);
    assign w_rs1_hit  = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    assign o_load_use = w_ex_load & i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall, flush and hold.
//            Define ID_EX_PERF_EN to add the saturating bubble_cnt_o counter.
// Revision : 1.0
// ============================================================================
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  wire          clk,
    input  wire          rst_n,
    input  wire          hold_i,
    input  wire          flush_i,
    id_ex_stage_if.slave bus,
    output logic         pc_write_o,
    output logic         ifid_write_o,
    output logic         load_use_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]  bubble_cnt_o
`endif
);

    logic              w_load_use;
    logic              w_bubble;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [2:0]        r_funct3;
    logic              r_funct7b5;
    logic [CTRL_W-1:0] r_ctrl;

    hazard_detect u_hazard_detect (
        .i_ex_valid    (r_valid),
        .i_ex_memread  (r_ctrl[CTRL_MEMREAD]),
        .i_ex_rd       (r_rd),
        .i_id_valid    (bus.id_valid_i),
        .i_id_rs1      (bus.id_rs1_i),
        .i_id_rs2      (bus.id_rs2_i),
        .i_id_rs1_used (bus.id_rs1_used_i),
        .i_id_rs2_used (bus.id_rs2_used_i),
        .o_load_use    (w_load_use)
    );

    assign w_bubble     = flush_i | w_load_use;
    assign load_use_o   = w_load_use;
    assign pc_write_o   = ~(w_load_use | hold_i);
    assign ifid_write_o = ~(w_load_use | hold_i);

    // Hold outranks flush; a bubble only clears valid/ctrl, data fields still load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_ctrl     <= CTRL_W'(CTRL_NOP);
        end else if (!hold_i) begin
            r_pc       <= bus.id_pc_i;
            r_rs1_data <= bus.id_rs1_data_i;
            r_rs2_data <= bus.id_rs2_data_i;
            r_imm      <= bus.id_imm_i;
            r_rs1      <= bus.id_rs1_i;
            r_rs2      <= bus.id_rs2_i;
            r_rd       <= bus.id_rd_i;
            r_funct3   <= bus.id_funct3_i;
            r_funct7b5 <= bus.id_funct7b5_i;
            if (w_bubble) begin
                r_valid <= 1'b0;
                r_ctrl  <= CTRL_W'(CTRL_NOP);
            end else begin
                r_valid <= bus.id_valid_i;
                r_ctrl  <= bus.id_valid_i ? bus.id_ctrl_i : CTRL_W'(CTRL_NOP);
            end
        end
    end

    assign bus.ex_valid_o    = r_valid;
    assign bus.ex_pc_o       = r_pc;
    assign bus.ex_rs1_data_o = r_rs1_data;
    assign bus.ex_rs2_data_o = r_rs2_data;
    assign bus.ex_imm_o      = r_imm;
    assign bus.ex_rs1_o      = r_rs1;
    assign bus.ex_rs2_o      = r_rs2;
    assign bus.ex_rd_o       = r_rd;
    assign bus.ex_funct3_o   = r_funct3;
    assign bus.ex_funct7b5_o = r_funct7b5;
    assign bus.ex_ctrl_o     = r_ctrl;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 32'd0;
        end else if (w_load_use && !hold_i && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed-vector scoreboard bench for id_ex_stage.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    typedef struct {
        bit        rst_n, hold, flush, valid;
        bit [4:0]  rs1, rs2, rd;
        bit        r1u, r2u;
        bit [7:0]  ctrl;
        bit [31:0] pc;
        bit        e_valid;
        bit [7:0]  e_ctrl;
        bit [4:0]  e_rd, e_rs1, e_rs2;
        bit [31:0] e_pc;
        bit        e_lu, e_pw;
    } vec_t;

    typedef struct {
        int        idx;
        bit        e_valid;
        bit [7:0]  e_ctrl;
        bit [4:0]  e_rd, e_rs1, e_rs2;
        bit [31:0] e_pc;
        bit        e_lu, e_pw;
        bit [31:0] e_cnt;
    } exp_t;

    localparam int NV = 24;

    logic clk;
    logic rst_n;
    logic hold_i;
    logic flush_i;
    logic pc_write_o;
    logic ifid_write_o;
    logic load_use_o;
    logic [31:0] bubble_cnt;

    vec_t vecs [NV];
    exp_t sb [$];
    int   vectors_applied;
    int   miscompares;

    id_ex_stage_if #(.XLEN(32), .CTRL_W(8)) bus ();

    id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .bus          (bus),
        .pc_write_o   (pc_write_o),
        .ifid_write_o (ifid_write_o),
        .load_use_o   (load_use_o)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_cnt_o (bubble_cnt)
`endif
    );

`ifndef ID_EX_PERF_EN
    assign bubble_cnt = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
            miscompares++;
        end
    endtask

    // Monitor: compares the oldest expectation each negative clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors_applied++;
                chk(e.idx, "ex_valid",    32'(bus.ex_valid_o),    32'(e.e_valid));
                chk(e.idx, "ex_ctrl",     32'(bus.ex_ctrl_o),     32'(e.e_ctrl));
                chk(e.idx, "ex_rd",       32'(bus.ex_rd_o),       32'(e.e_rd));
                chk(e.idx, "ex_rs1",      32'(bus.ex_rs1_o),      32'(e.e_rs1));
                chk(e.idx, "ex_rs2",      32'(bus.ex_rs2_o),      32'(e.e_rs2));
                chk(e.idx, "ex_pc",       bus.ex_pc_o,            e.e_pc);
                chk(e.idx, "ex_rs1_data", bus.ex_rs1_data_o,      e.e_pc * 3);
                chk(e.idx, "ex_rs2_data", bus.ex_rs2_data_o,      e.e_pc * 5);
                chk(e.idx, "ex_imm",      bus.ex_imm_o,           e.e_pc * 7);
                chk(e.idx, "ex_funct3",   32'(bus.ex_funct3_o),   32'(e.e_pc[4:2]));
                chk(e.idx, "ex_funct7b5", 32'(bus.ex_funct7b5_o), 32'(e.e_pc[5]));
                chk(e.idx, "load_use",    32'(load_use_o),        32'(e.e_lu));
                chk(e.idx, "pc_write",    32'(pc_write_o),        32'(e.e_pw));
                chk(e.idx, "ifid_write",  32'(ifid_write_o),      32'(e.e_pw));
`ifdef ID_EX_PERF_EN
                chk(e.idx, "bubble_cnt",  bubble_cnt,             e.e_cnt);
`endif
            end
        end
    end

    // Stimulus: ctrl 2B = lw, 81 = R-type, A1 = addi, 01 = plain regwrite
    initial begin
        exp_t  e;
        bit [31:0] cnt;
        vectors_applied = 0;
        miscompares     = 0;
        cnt             = 32'd0;
        //          rst hld fl  vl  rs1 rs2 rd  r1u r2u ctrl   pc        | ev ectl   erd ers1 ers2 epc      lu pw
        vecs[0]  = '{0, 0, 0, 0,  0,  0,  0, 0, 0, 8'h00, 32'h000,  0, 8'h00,  0,  0,  0, 32'h000, 0, 1};
        vecs[1]  = '{0, 1, 0, 0,  0,  0,  0, 0, 0, 8'h00, 32'h000,  0, 8'h00,  0,  0,  0, 32'h000, 0, 0};
        vecs[2]  = '{1, 0, 0, 1,  1,  2,  5, 1, 1, 8'h01, 32'h100,  0, 8'h00,  0,  0,  0, 32'h000, 0, 1};
        vecs[3]  = '{1, 0, 0, 1,  2,  0,  6, 1, 0, 8'h2B, 32'h104,  1, 8'h01,  5,  1,  2, 32'h100, 0, 1};
        vecs[4]  = '{1, 0, 0, 1,  6,  3,  7, 1, 1, 8'h81, 32'h108,  1, 8'h2B,  6,  2,  0, 32'h104, 1, 0};
        vecs[5]  = '{1, 0, 0, 1,  6,  3,  7, 1, 1, 8'h81, 32'h108,  0, 8'h00,  7,  6,  3, 32'h108, 0, 1};
        vecs[6]  = '{1, 0, 0, 1,  7,  9,  9, 1, 0, 8'h2B, 32'h10C,  1, 8'h81,  7,  6,  3, 32'h108, 0, 1};
        vecs[7]  = '{1, 0, 0, 1,  1,  9, 10, 1, 0, 8'hA1, 32'h110,  1, 8'h2B,  9,  7,  9, 32'h10C, 0, 1};
        vecs[8]  = '{1, 0, 0, 1,  1,  0,  0, 1, 0, 8'h2B, 32'h114,  1, 8'hA1, 10,  1,  9, 32'h110, 0, 1};
        vecs[9]  = '{1, 0, 0, 1,  0,  0, 11, 1, 1, 8'h81, 32'h118,  1, 8'h2B,  0,  1,  0, 32'h114, 0, 1};
        vecs[10] = '{1, 0, 0, 1,  3,  0, 12, 1, 0, 8'h2B, 32'h11C,  1, 8'h81, 11,  0,  0, 32'h118, 0, 1};
        vecs[11] = '{1, 0, 1, 1,  4, 12, 13, 1, 1, 8'h81, 32'h120,  1, 8'h2B, 12,  3,  0, 32'h11C, 1, 0};
        vecs[12] = '{1, 0, 0, 1,  4, 12, 13, 1, 1, 8'h81, 32'h120,  0, 8'h00, 13,  4, 12, 32'h120, 0, 1};
        vecs[13] = '{1, 0, 0, 1,  1,  0, 14, 1, 0, 8'h2B, 32'h124,  1, 8'h81, 13,  4, 12, 32'h120, 0, 1};
        vecs[14] = '{1, 1, 1, 1, 14,  0, 15, 1, 0, 8'h81, 32'h128,  1, 8'h2B, 14,  1,  0, 32'h124, 1, 0};
        vecs[15] = '{1, 1, 0, 1, 14,  0, 15, 1, 0, 8'h81, 32'h128,  1, 8'h2B, 14,  1,  0, 32'h124, 1, 0};
        vecs[16] = '{1, 0, 0, 1, 14,  0, 15, 1, 0, 8'h81, 32'h128,  1, 8'h2B, 14,  1,  0, 32'h124, 1, 0};
        vecs[17] = '{1, 0, 0, 1, 14,  0, 15, 1, 0, 8'h81, 32'h128,  0, 8'h00, 15, 14,  0, 32'h128, 0, 1};
        vecs[18] = '{1, 0, 0, 1,  1,  0, 16, 1, 0, 8'h2B, 32'h12C,  1, 8'h81, 15, 14,  0, 32'h128, 0, 1};
        vecs[19] = '{1, 1, 0, 1, 16,  0, 17, 1, 0, 8'h81, 32'h130,  1, 8'h2B, 16,  1,  0, 32'h12C, 1, 0};
        vecs[20] = '{0, 0, 0, 1, 16,  0, 17, 1, 0, 8'h81, 32'h130,  0, 8'h00,  0,  0,  0, 32'h000, 0, 1};
        vecs[21] = '{1, 0, 0, 0,  5,  0, 20, 1, 0, 8'h2B, 32'h200,  0, 8'h00,  0,  0,  0, 32'h000, 0, 1};
        vecs[22] = '{1, 0, 0, 0,  0,  0,  0, 0, 0, 8'h00, 32'h000,  0, 8'h00, 20,  5,  0, 32'h200, 0, 1};
        vecs[23] = '{1, 0, 0, 0,  0,  0,  0, 0, 0, 8'h00, 32'h000,  0, 8'h00,  0,  0,  0, 32'h000, 0, 1};

        rst_n   = 1'b0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        bus.id_valid_i    = 1'b0;
        bus.id_pc_i       = 32'd0;
        bus.id_rs1_data_i = 32'd0;
        bus.id_rs2_data_i = 32'd0;
        bus.id_imm_i      = 32'd0;
        bus.id_rs1_i      = 5'd0;
        bus.id_rs2_i      = 5'd0;
        bus.id_rd_i       = 5'd0;
        bus.id_rs1_used_i = 1'b0;
        bus.id_rs2_used_i = 1'b0;
        bus.id_funct3_i   = 3'd0;
        bus.id_funct7b5_i = 1'b0;
        bus.id_ctrl_i     = 8'd0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #2;
            // The edge just taken counts a bubble from the previous vector's conditions
            if (i > 0 && vecs[i-1].rst_n && vecs[i-1].e_lu && !vecs[i-1].hold)
                cnt = cnt + 32'd1;
            if (!vecs[i].rst_n)
                cnt = 32'd0;
            rst_n             = vecs[i].rst_n;
            hold_i            = vecs[i].hold;
            flush_i           = vecs[i].flush;
            bus.id_valid_i    = vecs[i].valid;
            bus.id_pc_i       = vecs[i].pc;
            bus.id_rs1_data_i = vecs[i].pc * 3;
            bus.id_rs2_data_i = vecs[i].pc * 5;
            bus.id_imm_i      = vecs[i].pc * 7;
            bus.id_rs1_i      = vecs[i].rs1;
            bus.id_rs2_i      = vecs[i].rs2;
            bus.id_rd_i       = vecs[i].rd;
            bus.id_rs1_used_i = vecs[i].r1u;
            bus.id_rs2_used_i = vecs[i].r2u;
            bus.id_funct3_i   = vecs[i].pc[4:2];
            bus.id_funct7b5_i = vecs[i].pc[5];
            bus.id_ctrl_i     = vecs[i].ctrl;
            e.idx     = i;
            e.e_valid = vecs[i].e_valid;
            e.e_ctrl  = vecs[i].e_ctrl;
            e.e_rd    = vecs[i].e_rd;
            e.e_rs1   = vecs[i].e_rs1;
            e.e_rs2   = vecs[i].e_rs2;
            e.e_pc    = vecs[i].e_pc;
            e.e_lu    = vecs[i].e_lu;
            e.e_pw    = vecs[i].e_pw;
            e.e_cnt   = cnt;
            sb.push_back(e);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++)
            @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            miscompares++;
        end
        if (vectors_applied != NV) begin
            $display("FAIL vector_count: got %0d, expected %0d", vectors_applied, NV);
            miscompares++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection. It captures decoded operands, immediate, register specifiers and control bits from ID, and presents them to EX, including the rs1/rs2 specifiers consumed by the EX-stage forwarding logic. It stalls PC and IF/ID and injects a bubble on load-use hazards, squashes on taken branches, and freezes on external hold.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 8, control bundle width (bit map in shared package)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold_i  in  1  external freeze (memory busy); ID/EX keeps contents
- flush_i  in  1  taken branch/jump resolved in EX; squash ID/EX
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  PC of ID instruction
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  5  register specifiers
- id_rs1_used_i, id_rs2_used_i  in  1  instruction actually reads rs1/rs2
- id_funct3_i  in  3; id_funct7b5_i  in  1  ALU-control fields
- id_ctrl_i  in  CTRL_W  {aluop[1:0], alusrc, branch, memtoreg, memwrite, memread, regwrite} (bit 0 = regwrite)
- ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o, ex_ctrl_o  out  matching widths  registered ID/EX contents
- pc_write_o  out  1  0 = hold PC
- ifid_write_o  out  1  0 = hold IF/ID register
- load_use_o  out  1  load-use hazard detected this cycle

## Operation
- Load-use detect (combinational): load_use = ex_valid_o & ex_ctrl_o.memread & (ex_rd_o != 0) & id_valid_i & ((id_rs1_used_i & id_rs1_i == ex_rd_o) | (id_rs2_used_i & id_rs2_i == ex_rd_o)).
- pc_write_o = ifid_write_o = ~(load_use | hold_i).
- Register update priority at posedge, highest first:
  - hold_i = 1: all ID/EX fields keep their values. A simultaneous flush_i is ignored; the flush source holds it until hold drops.
  - flush_i = 1: ex_valid_o ← 0 and ex_ctrl_o ← 0. Other fields are don't-care, implemented as load.
  - load_use = 1: bubble, same as flush. IF/ID and PC are held, so the dependent instruction re-evaluates next cycle.
  - Otherwise: load all id_* fields. ex_valid_o ← id_valid_i. ex_ctrl_o ← id_valid_i ? id_ctrl_i : 0.
- A bubble always carries ctrl = 0: regwrite = 0 and memread = 0, so a bubble never forwards, writes, or triggers a stall.
- Register x0 as the load destination never stalls.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Load-use costs exactly one bubble cycle. The next cycle the load is in MEM, load_use deasserts, and forwarding resolves from MEM/WB.
- pc_write_o, ifid_write_o and load_use_o are combinational from ex_* registers and id_* inputs, with no registered delay.
- Reset (async assert, sync deassert by clock domain):
  - All ex_* outputs are 0, so ex_valid_o = 0 and ex_ctrl_o = 0.
  - With no valid EX instruction, pc_write_o = ifid_write_o = ~hold_i.
- Reset mid-stall: the stall clears immediately because ex_valid_o falls to 0.
- Back-to-back loads with dependency chains: each dependent consumer gets exactly one bubble.

## Configuration
- ID_EX_PERF_EN defined:
  - Adds output bubble_cnt_o (32 bits), a saturating count of cycles where load_use = 1 and hold_i = 0.
  - Clears on reset and holds at 32'hFFFF_FFFF.
- ID_EX_PERF_EN undefined: no counter and no port. Behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W and the bit-index constants CTRL_REGWRITE … CTRL_ALUOP.
  - Typedef ctrl_t.
  - Constant CTRL_NOP = 0.
- Sub-module hazard_detect: purely combinational load-use compare, producing load_use. It is instantiated once here.

## Test plan
- Independent ALU instruction: id_valid_i = 1, ctrl = 8'h01, rd = 5 → next cycle ex_rd_o = 5, ex_ctrl_o = 8'h01, ex_valid_o = 1, pc_write_o = 1.
- Load-use:
  - Stimulus: EX holds lw x6 (memread = 1, rd = 6); ID holds add with rs1 = 6, rs1_used = 1.
  - Response: load_use_o = 1, pc_write_o = ifid_write_o = 0; next cycle ex_ctrl_o = 0, ex_valid_o = 0.
  - The cycle after: the add loads normally.
- Load to x0 or rs2_used = 0 with matching rs2 → load_use_o = 0, no bubble.
- flush_i = 1 concurrent with load_use → ex_ctrl_o = 0 next cycle. hold_i = 1 concurrent with flush_i → ex_* unchanged.
- rst_n pulsed low mid-stall → ex_valid_o = 0 and ex_ctrl_o = 0 asynchronously; pc_write_o = 1 with hold_i = 0.
- ID_EX_PERF_EN: three separate load-use events → bubble_cnt_o = 3; a load-use cycle under hold_i = 1 is not counted.
